// File: rtl/mem_access_stage.sv
// mem_access_stage: RV64I load/store unit sitting between execute and writeback.
// Drives a req/gnt/rvalid data-memory port, aligns byte lanes for stores,
// extracts and extends load data, and stalls upstream while an access is in flight.
module mem_access_stage #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic [1:0]      out_err
);

  localparam int NB = XLEN / 8;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [NB-1:0]   be_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            reg_write_q;
  logic [15:0]     cnt_q;

  logic            accept;
  logic            is_mem;
  logic            misaligned;
  logic            bad_access;
  logic [NB-1:0]   size_mask;
  logic [NB-1:0]   be_in;
  logic [XLEN-1:0] wdata_in;
  logic            rsp_done;
  logic            timeout_hit;
  logic [XLEN-1:0] load_result;

  // Shift the read word down to the addressed lane, then truncate and extend by access type.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] rdata,
                                                  input logic [2:0] off,
                                                  input logic [2:0] f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  res = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b100:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  res = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign in_ready   = (state == S_IDLE);
  assign dmem_req   = (state == S_REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign dmem_be    = dmem_req ? be_q : '0;
  assign dmem_wdata = dmem_req ? wdata_q : '0;

  // Decode the incoming instruction: lane mask, store data alignment and legality.
  always_comb begin
    accept     = in_valid & in_ready;
    is_mem     = mem_read | mem_write;
    size_mask  = '0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'd0: size_mask = 8'h01;
      2'd1: begin size_mask = 8'h03; misaligned = alu_result[0];      end
      2'd2: begin size_mask = 8'h0F; misaligned = |alu_result[1:0];   end
      default: begin size_mask = 8'hFF; misaligned = |alu_result[2:0]; end
    endcase
    bad_access  = misaligned | (funct3 == 3'b111) | (mem_write & funct3[2]) |
                  (mem_read & mem_write);
    be_in       = size_mask << alu_result[2:0];
    wdata_in    = rs2_data << {alu_result[2:0], 3'b000};
    rsp_done    = ((state == S_REQ) & dmem_gnt & dmem_rvalid) |
                  ((state == S_WAIT) & dmem_rvalid);
    timeout_hit = (state == S_WAIT) & ~dmem_rvalid & (TO_LIMIT != 16'd0) &
                  ((cnt_q + 16'd1) == TO_LIMIT);
    load_result = extend_load(dmem_rdata, addr_q[2:0], funct3_q);
  end

  // Access FSM with registered writeback outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      rd_q          <= 5'd0;
      reg_write_q   <= 1'b0;
      cnt_q         <= 16'd0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd        <= 5'd0;
      out_reg_write <= 1'b0;
      out_err       <= 2'b00;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              out_valid     <= 1'b1;
              out_data      <= alu_result;
              out_rd        <= rd;
              out_reg_write <= reg_write;
              out_err       <= 2'b00;
            end else if (bad_access) begin
              out_valid     <= 1'b1;
              out_data      <= alu_result;
              out_rd        <= rd;
              out_reg_write <= 1'b0;
              out_err       <= 2'b01;
            end else begin
              addr_q      <= alu_result;
              wdata_q     <= wdata_in;
              be_q        <= be_in;
              we_q        <= mem_write;
              funct3_q    <= funct3;
              rd_q        <= rd;
              reg_write_q <= reg_write;
              state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            cnt_q <= 16'd0;
            state <= rsp_done ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_done) begin
            state <= S_IDLE;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (rsp_done) begin
        out_valid     <= 1'b1;
        out_data      <= we_q ? addr_q : load_result;
        out_rd        <= rd_q;
        out_reg_write <= reg_write_q;
        out_err       <= 2'b00;
      end else if (timeout_hit) begin
        out_valid     <= 1'b1;
        out_data      <= addr_q;
        out_rd        <= rd_q;
        out_reg_write <= 1'b0;
        out_err       <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage.
// Stimulus pushes hand-computed writeback results (with the cycle they must appear in);
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, mem_read, mem_write, reg_write;
  logic [2:0]  funct3;
  logic [63:0] alu_result, rs2_data;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;
  logic        out_valid, out_reg_write;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  out_err;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   a;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_data(out_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_err(out_err)
  );

  // Cycle index: cycle n is the interval after the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result, in the right cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checkOutput("out_valid_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checkOutput("out_data", out_data, mon_e.data);
        checkOutput("out_rd", 64'(out_rd), 64'(mon_e.rd));
        checkOutput("out_reg_write", 64'(out_reg_write), 64'(mon_e.rw));
        checkOutput("out_err", 64'(out_err), 64'(mon_e.err));
        checkOutput("out_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic expectOut(input logic [63:0] data, input logic [4:0] r, input logic rw,
                           input logic [1:0] err, input int c);
    exp_t e;
    e.data = data; e.rd = r; e.rw = rw; e.err = err; e.cyc = c;
    sb.push_back(e);
  endtask

  // Presents one instruction for a single cycle; returns the cycle index right after acceptance.
  task automatic applyStimulus(input logic mr, input logic mw, input logic [2:0] f3,
                               input logic [63:0] alu, input logic [63:0] rs2,
                               input logic [4:0] r, input logic rw, output int acc);
    in_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f3;
    alu_result = alu; rs2_data = rs2; rd = r; reg_write = rw;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Instruction that must complete one cycle after acceptance without touching memory.
  task automatic issueImm(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [63:0] alu, input logic [4:0] r, input logic rw,
                          input logic exp_rw, input logic [1:0] err);
    int acc;
    applyStimulus(mr, mw, f3, alu, 64'h0, r, rw, acc);
    expectOut(alu, r, exp_rw, err, acc);
    @(negedge clk);
    checkOutput("no_dmem_req", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
  endtask

  // Memory responder: grant after k REQ cycles, rvalid rv cycles after grant (0 = same cycle).
  // With respond=0 no rvalid is given and the timeout window is observed instead.
  task automatic memRespond(input int k, input int rv, input logic respond,
                            input logic [63:0] rdata, input logic we,
                            input logic [63:0] addr, input logic [7:0] be,
                            input logic [63:0] wdata);
    logic held;
    logic stalled;
    logic quiet;
    int   n;
    held = 1'b1; stalled = 1'b1; quiet = 1'b1;
    for (int i = 0; i <= k; i++) begin
      dmem_gnt = (i == k);
      if (i == k && rv == 0 && respond) begin
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
      end
      @(negedge clk);
      if (i == 0) begin
        checkOutput("dmem_req", 64'(dmem_req), 64'd1);
        checkOutput("dmem_we", 64'(dmem_we), 64'(we));
        checkOutput("dmem_addr", dmem_addr, addr);
        checkOutput("dmem_be", 64'(dmem_be), 64'(be));
        checkOutput("dmem_wdata", dmem_wdata, wdata);
      end
      if (!(dmem_req === 1'b1 && dmem_we === we && dmem_addr === addr &&
            dmem_be === be && dmem_wdata === wdata)) held = 1'b0;
      if (in_ready !== 1'b0) stalled = 1'b0;
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    end
    if (rv > 0) begin
      n = respond ? rv : 4;
      for (int j = 1; j <= n; j++) begin
        dmem_rvalid = respond && (j == rv);
        dmem_rdata  = rdata;
        @(negedge clk);
        if (dmem_req !== 1'b0) quiet = 1'b0;
        if (in_ready !== 1'b0) stalled = 1'b0;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
      end
    end
    checkOutput("req_held_stable", 64'(held), 64'd1);
    checkOutput("stalled_upstream", 64'(stalled), 64'd1);
    checkOutput("req_low_in_wait", 64'(quiet), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    alu_result = '0; rs2_data = '0; rd = '0; reg_write = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #2;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("reset_out_err", 64'(out_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-memory op passes through in one cycle.
    issueImm(1'b0, 1'b0, 3'b000, 64'h1234_5678_9ABC_DEF0, 5'd3, 1'b1, 1'b1, 2'b00);

    // LB at 0x1003: byte 3 of the word is 0x80, sign-extended.
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 5'd5, 1'b1, a);
    expectOut(64'hFFFF_FFFF_FFFF_FF80, 5'd5, 1'b1, 2'b00, a + 1 + 1 + 1);
    memRespond(1, 1, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 64'h1000, 8'h08, 64'h0);

    // SH at 0x2006 with grant and rvalid together (minimum latency).
    applyStimulus(1'b0, 1'b1, 3'b001, 64'h2006, 64'hDEAD_0000_0000_1234, 5'd0, 1'b0, a);
    expectOut(64'h2006, 5'd0, 1'b0, 2'b00, a + 1);
    memRespond(0, 0, 1'b1, 64'h0, 1'b1, 64'h2000, 8'hC0, 64'h1234_0000_0000_0000);

    // Misaligned and illegal accesses: error 01, no memory request.
    issueImm(1'b1, 1'b0, 3'b010, 64'h2002, 5'd7, 1'b1, 1'b0, 2'b01);
    issueImm(1'b1, 1'b0, 3'b111, 64'h0000, 5'd8, 1'b1, 1'b0, 2'b01);
    issueImm(1'b0, 1'b1, 3'b100, 64'h0010, 5'd0, 1'b0, 1'b0, 2'b01);
    issueImm(1'b1, 1'b1, 3'b011, 64'h0020, 5'd9, 1'b1, 1'b0, 2'b01);

    // LD with grant after 3 cycles and rvalid 2 cycles later.
    applyStimulus(1'b1, 1'b0, 3'b011, 64'h3000, 64'h0, 5'd10, 1'b1, a);
    expectOut(64'h0123_4567_89AB_CDEF, 5'd10, 1'b1, 2'b00, a + 3 + 2 + 1);
    memRespond(3, 2, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h3000, 8'hFF, 64'h0);

    // Halfword and word loads at nonzero lanes, signed and unsigned.
    applyStimulus(1'b1, 1'b0, 3'b001, 64'h5002, 64'h0, 5'd11, 1'b1, a);
    expectOut(64'hFFFF_FFFF_FFFF_F00D, 5'd11, 1'b1, 2'b00, a + 2);
    memRespond(0, 1, 1'b1, 64'h0000_0000_F00D_0000, 1'b0, 64'h5000, 8'h0C, 64'h0);
    applyStimulus(1'b1, 1'b0, 3'b101, 64'h5002, 64'h0, 5'd12, 1'b1, a);
    expectOut(64'h0000_0000_0000_F00D, 5'd12, 1'b1, 2'b00, a + 1);
    memRespond(0, 0, 1'b1, 64'h0000_0000_F00D_0000, 1'b0, 64'h5000, 8'h0C, 64'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 64'h6004, 64'h0, 5'd13, 1'b1, a);
    expectOut(64'hFFFF_FFFF_8765_4321, 5'd13, 1'b1, 2'b00, a + 1);
    memRespond(0, 0, 1'b1, 64'h8765_4321_0000_0000, 1'b0, 64'h6000, 8'hF0, 64'h0);
    applyStimulus(1'b1, 1'b0, 3'b110, 64'h6004, 64'h0, 5'd14, 1'b1, a);
    expectOut(64'h0000_0000_8765_4321, 5'd14, 1'b1, 2'b00, a + 1 + 1 + 1);
    memRespond(1, 1, 1'b1, 64'h8765_4321_0000_0000, 1'b0, 64'h6000, 8'hF0, 64'h0);

    // Byte and doubleword stores.
    applyStimulus(1'b0, 1'b1, 3'b000, 64'h7005, 64'h0000_0000_0000_55AB, 5'd0, 1'b0, a);
    expectOut(64'h7005, 5'd0, 1'b0, 2'b00, a + 2 + 1);
    memRespond(2, 0, 1'b1, 64'h0, 1'b1, 64'h7000, 8'h20, 64'h0055_AB00_0000_0000);
    applyStimulus(1'b0, 1'b1, 3'b011, 64'h8000, 64'hCAFE_BABE_DEAD_BEEF, 5'd0, 1'b0, a);
    expectOut(64'h8000, 5'd0, 1'b0, 2'b00, a + 1 + 1);
    memRespond(0, 1, 1'b1, 64'h0, 1'b1, 64'h8000, 8'hFF, 64'hCAFE_BABE_DEAD_BEEF);

    // Bus timeout four cycles after grant, then a late rvalid that must be ignored.
    applyStimulus(1'b1, 1'b0, 3'b011, 64'h4008, 64'h0, 5'd15, 1'b1, a);
    expectOut(64'h4008, 5'd15, 1'b0, 2'b10, a + 1 + 1 + 4);
    memRespond(1, 1, 1'b0, 64'h0, 1'b0, 64'h4008, 8'hFF, 64'h0);
    dmem_rvalid = 1'b1; dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(posedge clk); #1;

    // Reset while waiting for rvalid: outputs clear at once, access is abandoned.
    applyStimulus(1'b1, 1'b0, 3'b011, 64'h9000, 64'h0, 5'd16, 1'b1, a);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("wait_in_ready", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", out_data, 64'h0);
    checkOutput("rst_out_reg_write", 64'(out_reg_write), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    issueImm(1'b0, 1'b0, 3'b000, 64'h0000_0000_0000_002A, 5'd17, 1'b1, 1'b1, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
